// File: rtl/alu_pkg.sv
// Shared types for the sequential one-bit-per-cycle shifter: FSM state,
// latched operation descriptor and the direction/fill encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } e_shift_state;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic FILL_ZERO = 1'b0;
  localparam logic FILL_SIGN = 1'b1;

  typedef struct packed {
    logic right;
    logic arith;
  } shift_op_t;

  // Sign fill applies only to right shifts; a left shift with func7[5] set is plain SLL.
  function automatic shift_op_t mk_op(input logic right, input logic f7_5);
    shift_op_t op;
    op.right = right;
    op.arith = (right == DIR_RIGHT) ? f7_5 : FILL_ZERO;
    return op;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit shift step: moves acc one position left or right with the
// selected fill bit. Purely combinational.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] acc_i,
  input  logic          right_i,
  input  logic          arith_i,
  output logic [DW-1:0] acc_o
);

  logic fill;

  always_comb begin
    fill  = (arith_i == FILL_SIGN) ? acc_i[DW-1] : 1'b0;
    acc_o = '0;
    if (right_i == DIR_RIGHT) acc_o = {fill, acc_i[DW-1:1]};
    else                      acc_o = {acc_i[DW-2:0], 1'b0};
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Sequential SLL/SRL/SRA unit: one bit per cycle, stalls the issuing stage
// while busy, and publishes a registered result with a one-cycle valid pulse.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    right_i,
  input  logic                    func7_5_i,
  input  logic [DW-1:0]           operand_i,
  input  logic [$clog2(DW)-1:0]   shamt_i,
  input  logic                    flush_i,
  output logic                    ready_o,
  output logic                    stall_o,
  output logic                    valid_o,
  output logic [DW-1:0]           result_o
);

  localparam int SW = $clog2(DW);

  e_shift_state  state_q, state_d;
  logic [DW-1:0] acc_q, acc_d, acc_step;
  logic [DW-1:0] result_q, result_d;
  logic [SW-1:0] cnt_q, cnt_d;
  shift_op_t     op_q, op_d;
  logic          valid_q, valid_d;

  alu_shift_step #(.DW(DW)) u_step (
    .acc_i   (acc_q),
    .right_i (op_q.right),
    .arith_i (op_q.arith),
    .acc_o   (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    valid_d  = 1'b0;
    if (flush_i) begin
      // Abort wins over everything, including a same-cycle start in IDLE.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            acc_d   = operand_i;
            cnt_d   = shamt_i;
            op_d    = mk_op(right_i, func7_5_i);
            state_d = (shamt_i == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_d = acc_step;
          cnt_d = cnt_q - SW'(1);
          if (cnt_q <= SW'(1)) state_d = S_DONE;
        end
        S_DONE: begin
          result_d = acc_q;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign stall_o  = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq: directed requests push expected results,
// a negedge monitor pops and checks value and latency on every valid_o.
module tb_alu_shift_seq;

  localparam int DW = 32;
  localparam int SW = $clog2(DW);

  logic          clk, rst_n, start_i, right_i, func7_5_i, flush_i;
  logic [DW-1:0] operand_i;
  logic [SW-1:0] shamt_i;
  logic          ready_o, stall_o, valid_o;
  logic [DW-1:0] result_o;

  alu_shift_seq #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .right_i   (right_i),
    .func7_5_i (func7_5_i),
    .operand_i (operand_i),
    .shamt_i   (shamt_i),
    .flush_i   (flush_i),
    .ready_o   (ready_o),
    .stall_o   (stall_o),
    .valid_o   (valid_o),
    .result_o  (result_o)
  );

  typedef struct {
    logic [DW-1:0] res;
    int            sh;
    int            acc_idx;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every valid_o must match the oldest outstanding request.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        // Edges from accept to valid are shamt+1, i.e. shamt+2 cycles counting the accept cycle.
        chk("latency", 32'(cyc - e.acc_idx + 1), 32'(e.sh + 2));
      end
    end
  end

  task automatic issue(input logic now, input logic r, input logic a, input logic [DW-1:0] op,
                       input int sh, input logic track, input logic [DW-1:0] exp_res,
                       output logic v_at_acc);
    int guard;
    exp_t e;
    guard = 0;
    if (!now) @(negedge clk);
    start_i = 1'b1; right_i = r; func7_5_i = a; operand_i = op; shamt_i = SW'(sh);
    while (ready_o !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("issue_timeout", 32'd1, 32'd0);
    v_at_acc = valid_o;
    @(posedge clk);
    #1;
    if (track) begin
      e.res = exp_res; e.sh = sh; e.acc_idx = cyc;
      sb.push_back(e);
    end
    start_i = 1'b0; operand_i = '0; shamt_i = '0; right_i = 1'b0; func7_5_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || ready_o !== 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  logic v;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; right_i = 1'b0; func7_5_i = 1'b0;
    flush_i = 1'b0; operand_i = '0; shamt_i = '0;
    #12;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 1'b1, 1'b0, 32'h8000_0000, 4,  1'b1, 32'h0800_0000, v);  // SRL
    drain();
    issue(1'b0, 1'b1, 1'b1, 32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, v);  // SRA max
    drain();
    issue(1'b0, 1'b0, 1'b0, 32'h0000_0001, 0,  1'b1, 32'h0000_0001, v);  // SLL zero
    drain();
    issue(1'b0, 1'b0, 1'b0, 32'h0000_0001, 31, 1'b1, 32'h8000_0000, v);
    drain();
    issue(1'b0, 1'b1, 1'b1, 32'h7000_0000, 4,  1'b1, 32'h0700_0000, v);  // SRA positive
    issue(1'b0, 1'b1, 1'b1, 32'hF000_0001, 1,  1'b1, 32'hF800_0000, v);
    issue(1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 16, 1'b1, 32'hABCD_0000, v);  // f7_5 ignored on left
    issue(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 31, 1'b1, 32'h0000_0001, v);
    drain();

    // Busy: a held start with different operands must not disturb the running op.
    issue(1'b0, 1'b0, 1'b0, 32'h0000_0003, 8, 1'b1, 32'h0000_0300, v);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_i = 1'b1; operand_i = 32'hFFFF_0000; right_i = 1'b1; shamt_i = '0;
      if (i == 2) begin
        chk("busy_ready", 32'(ready_o), 32'd0);
        chk("busy_stall", 32'(stall_o), 32'd1);
      end
    end
    start_i = 1'b0; operand_i = '0; right_i = 1'b0;
    drain();

    // Flush at SHIFT cycle 3: idle next cycle, no pulse, result kept.
    issue(1'b0, 1'b0, 1'b0, 32'h1234_5678, 8, 1'b0, '0, v);
    repeat (3) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_result", result_o, 32'h0000_0300);
    repeat (15) @(negedge clk);
    chk("flush_result_later", result_o, 32'h0000_0300);

    // Flush beats a simultaneous start in IDLE.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; operand_i = 32'hDEAD_BEEF; shamt_i = '0;
    @(posedge clk);
    #1;
    start_i = 1'b0; flush_i = 1'b0; operand_i = '0;
    chk("flush_prio_ready", 32'(ready_o), 32'd1);
    repeat (5) @(negedge clk);
    chk("flush_prio_result", result_o, 32'h0000_0300);

    // Reset mid-shift discards the op immediately.
    issue(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 10, 1'b0, '0, v);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_result", result_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First edge after release accepts; second request lands in the valid cycle.
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0004, 1, 1'b1, 32'h0000_0002, v);
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0004, 1, 1'b1, 32'h0000_0002, v);
    chk("b2b_accept_in_valid", 32'(v), 32'd1);
    drain();
    repeat (15) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
